// File: rtl/score_lives_keeper_if.sv
// Game-event interface for score_lives_keeper.
// Carries the collision/frame inputs and the score/lives/state outputs.
interface score_lives_keeper_if;
  logic        startOfFrame;
  logic        startGame;
  logic        collisionSmileyObstacleGood;
  logic        collisionSmileyObstacleBad;
  logic        collisionSmileyBumperPulse;
  logic        collisionSmileySpringPulse;
  logic        collisionSmileyBottom;
  logic [3:0]  scoreDigit;
  logic [15:0] score;
  logic [2:0]  lives;
  logic [1:0]  gameState;
  logic        ballReset;
  logic        scoreChanged;

  // Producer of game events, consumer of score/lives/state
  modport master (
    output startOfFrame, startGame, collisionSmileyObstacleGood,
           collisionSmileyObstacleBad, collisionSmileyBumperPulse,
           collisionSmileySpringPulse, collisionSmileyBottom, scoreDigit,
    input  score, lives, gameState, ballReset, scoreChanged
  );

  // The score/lives keeper itself
  modport slave (
    input  startOfFrame, startGame, collisionSmileyObstacleGood,
           collisionSmileyObstacleBad, collisionSmileyBumperPulse,
           collisionSmileySpringPulse, collisionSmileyBottom, scoreDigit,
    output score, lives, gameState, ballReset, scoreChanged
  );
endinterface

// File: rtl/score_lives_keeper.sv
// score_lives_keeper: latches per-frame collision events, applies them at the
// next frame boundary to a 4-digit BCD score, tracks lives and game state.
// Optional macro BONUS_LIFE_EN: extra life whenever the thousands digit rises.
module score_lives_keeper #(
  parameter int unsigned INIT_LIVES       = 3,
  parameter int unsigned MAX_LIVES        = 7,
  parameter int unsigned BUMPER_POINTS    = 5,
  parameter int unsigned BAD_PENALTY      = 3,
  parameter int unsigned BALL_LOST_FRAMES = 60
) (
  input logic                 clk,
  input logic                 resetN,
  score_lives_keeper_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(BALL_LOST_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_BALL_LOST = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_e;

  // Single-digit BCD add into the units digit, saturating at 9999
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [3:0] b);
    logic [15:0] r;
    logic        c;
    logic [4:0]  s;
    r = '0;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[i*4 +: 4]} + {4'd0, c} + ((i == 0) ? {1'b0, b} : 5'd0);
      if (s > 5'd9) begin
        r[i*4 +: 4] = 4'(s - 5'd10);
        c = 1'b1;
      end else begin
        r[i*4 +: 4] = s[3:0];
        c = 1'b0;
      end
    end
    return c ? 16'h9999 : r;
  endfunction

  // Single-digit BCD subtract from the units digit, saturating at 0
  function automatic logic [15:0] bcd_sub_sat(input logic [15:0] a, input logic [3:0] b);
    logic [15:0] r;
    logic        bw;
    logic [4:0]  s;
    r  = '0;
    bw = 1'b0;
    s  = '0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[i*4 +: 4]} - {4'd0, bw} - ((i == 0) ? {1'b0, b} : 5'd0);
      if (s[4]) begin
        r[i*4 +: 4] = 4'(s + 5'd10);
        bw = 1'b1;
      end else begin
        r[i*4 +: 4] = s[3:0];
        bw = 1'b0;
      end
    end
    return bw ? 16'h0000 : r;
  endfunction

  state_e             state_q, state_d;
  logic [15:0]        score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ball_reset_q, ball_reset_d;
  logic               score_changed_q, score_changed_d;
  logic               pend_good_q, pend_good_d, pend_bad_q, pend_bad_d;
  logic               pend_bump_q, pend_bump_d, pend_bottom_q, pend_bottom_d;
  logic [3:0]         pend_digit_q, pend_digit_d;
  logic               app_valid_q, app_valid_d;
  logic               app_good_q, app_good_d, app_bad_q, app_bad_d;
  logic               app_bump_q, app_bump_d, app_bottom_q, app_bottom_d;
  logic [3:0]         app_digit_q, app_digit_d;
  logic [15:0]        sum_c;
  logic [2:0]         lives_c;
  logic               base_good_c;

  // Spring hits are accepted but carry no game consequence
  logic unused_spring;
  assign unused_spring = bus.collisionSmileySpringPulse;

  // Next-state: event capture, frame hand-over, score apply and game FSM
  always_comb begin
    state_d         = state_q;
    score_d         = score_q;
    lives_d         = lives_q;
    cnt_d           = cnt_q;
    ball_reset_d    = 1'b0;
    score_changed_d = 1'b0;
    pend_good_d     = 1'b0;
    pend_bad_d      = 1'b0;
    pend_bump_d     = 1'b0;
    pend_bottom_d   = 1'b0;
    pend_digit_d    = pend_digit_q;
    app_valid_d     = bus.startOfFrame;
    app_good_d      = app_good_q;
    app_bad_d       = app_bad_q;
    app_bump_d      = app_bump_q;
    app_bottom_d    = app_bottom_q;
    app_digit_d     = app_digit_q;
    sum_c           = score_q;
    lives_c         = lives_q;
    base_good_c     = 1'b0;

    // Frame boundary: hand pending events over for next-cycle apply
    if (bus.startOfFrame) begin
      app_good_d   = pend_good_q;
      app_bad_d    = pend_bad_q;
      app_bump_d   = pend_bump_q;
      app_bottom_d = pend_bottom_q;
      app_digit_d  = pend_digit_q;
    end

    // Sticky capture; a boundary-cycle event lands in the fresh frame
    if (state_q == ST_PLAYING) begin
      base_good_c   = bus.startOfFrame ? 1'b0 : pend_good_q;
      pend_good_d   = base_good_c | bus.collisionSmileyObstacleGood;
      pend_bad_d    = (bus.startOfFrame ? 1'b0 : pend_bad_q) | bus.collisionSmileyObstacleBad;
      pend_bump_d   = (bus.startOfFrame ? 1'b0 : pend_bump_q) | bus.collisionSmileyBumperPulse;
      pend_bottom_d = (bus.startOfFrame ? 1'b0 : pend_bottom_q) | bus.collisionSmileyBottom;
      if (bus.collisionSmileyObstacleGood && !base_good_c) begin
        pend_digit_d = bus.scoreDigit;
      end
    end else begin
      pend_digit_d = 4'd0;
    end

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (bus.startGame) begin
          score_d      = 16'h0000;
          lives_d      = 3'(INIT_LIVES);
          cnt_d        = '0;
          ball_reset_d = 1'b1;
          state_d      = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        if (app_valid_q) begin
          if (app_good_q) sum_c = bcd_add_sat(sum_c, app_digit_q);
          if (app_bump_q) sum_c = bcd_add_sat(sum_c, 4'(BUMPER_POINTS));
          if (app_bad_q)  sum_c = bcd_sub_sat(sum_c, 4'(BAD_PENALTY));
          score_d         = sum_c;
          score_changed_d = (sum_c != score_q);
          if (app_bottom_q) begin
            if (lives_q == 3'd1) begin
              lives_c = 3'd0;
              state_d = ST_GAME_OVER;
            end else begin
              lives_c = lives_q - 3'd1;
              state_d = ST_BALL_LOST;
              cnt_d   = '0;
            end
          end
`ifdef BONUS_LIFE_EN
          if (state_d != ST_GAME_OVER && sum_c[15:12] > score_q[15:12] &&
              lives_c < 3'(MAX_LIVES)) begin
            lives_c = lives_c + 3'd1;
          end
`endif
          lives_d = lives_c;
        end
      end
      ST_BALL_LOST: begin
        if (bus.startOfFrame) begin
          if (cnt_q + CNT_W'(1) == CNT_W'(BALL_LOST_FRAMES)) begin
            cnt_d        = '0;
            ball_reset_d = 1'b1;
            state_d      = ST_PLAYING;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q         <= ST_IDLE;
      score_q         <= '0;
      lives_q         <= '0;
      cnt_q           <= '0;
      ball_reset_q    <= 1'b0;
      score_changed_q <= 1'b0;
      pend_good_q     <= 1'b0;
      pend_bad_q      <= 1'b0;
      pend_bump_q     <= 1'b0;
      pend_bottom_q   <= 1'b0;
      pend_digit_q    <= '0;
      app_valid_q     <= 1'b0;
      app_good_q      <= 1'b0;
      app_bad_q       <= 1'b0;
      app_bump_q      <= 1'b0;
      app_bottom_q    <= 1'b0;
      app_digit_q     <= '0;
    end else begin
      state_q         <= state_d;
      score_q         <= score_d;
      lives_q         <= lives_d;
      cnt_q           <= cnt_d;
      ball_reset_q    <= ball_reset_d;
      score_changed_q <= score_changed_d;
      pend_good_q     <= pend_good_d;
      pend_bad_q      <= pend_bad_d;
      pend_bump_q     <= pend_bump_d;
      pend_bottom_q   <= pend_bottom_d;
      pend_digit_q    <= pend_digit_d;
      app_valid_q     <= app_valid_d;
      app_good_q      <= app_good_d;
      app_bad_q       <= app_bad_d;
      app_bump_q      <= app_bump_d;
      app_bottom_q    <= app_bottom_d;
      app_digit_q     <= app_digit_d;
    end
  end

  assign bus.score        = score_q;
  assign bus.lives        = lives_q;
  assign bus.gameState    = state_q;
  assign bus.ballReset    = ball_reset_q;
  assign bus.scoreChanged = score_changed_q;

endmodule

// File: tb/tb_score_lives_keeper.sv
// Bench for score_lives_keeper: directed game scenarios plus random play,
// checked every cycle against a decimal-arithmetic game model.
module tb_score_lives_keeper;
  localparam int INIT   = 3;
  localparam int MAXL   = 7;
  localparam int BUMP   = 5;
  localparam int PEN    = 3;
  localparam int FRAMES = 60;
  localparam int ST_IDLE = 0, ST_PLAY = 1, ST_LOST = 2, ST_OVER = 3;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  score_lives_keeper_if bus ();
  score_lives_keeper dut (.clk(clk), .resetN(resetN), .bus(bus));

  int n_errors;
  int n_checks;

  // Game model: score kept as a plain decimal integer
  int m_state, m_score, m_lives, m_cnt;
  bit m_br, m_sc;
  bit p_good, p_bad, p_bump, p_bot;
  int p_dig;
  bit a_valid, a_good, a_bad, a_bump, a_bot;
  int a_dig;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int v);
    return (v / 1000) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  task automatic model_step(input bit rst, input bit sof, input bit sg, input bit g,
                            input bit bd, input bit bp, input bit bt, input int dig);
    int s, v, prev, nd;
    bit ng, nb, np, nt;
    m_br = 0;
    m_sc = 0;
    if (rst) begin
      m_state = ST_IDLE; m_score = 0; m_lives = 0; m_cnt = 0;
      p_good = 0; p_bad = 0; p_bump = 0; p_bot = 0; p_dig = 0;
      a_valid = 0; a_good = 0; a_bad = 0; a_bump = 0; a_bot = 0; a_dig = 0;
      return;
    end
    s  = m_state;
    ng = sof ? 1'b0 : p_good;
    nb = sof ? 1'b0 : p_bad;
    np = sof ? 1'b0 : p_bump;
    nt = sof ? 1'b0 : p_bot;
    nd = p_dig;
    if (s == ST_PLAY) begin
      if (g && !ng) nd = dig;
      ng = ng | g; nb = nb | bd; np = np | bp; nt = nt | bt;
    end else begin
      ng = 0; nb = 0; np = 0; nt = 0; nd = 0;
    end
    if (s == ST_PLAY && a_valid) begin
      prev = m_score;
      v = m_score + (a_good ? a_dig : 0) + (a_bump ? BUMP : 0);
      if (v > 9999) v = 9999;
      if (a_bad) v = v - PEN;
      if (v < 0) v = 0;
      m_sc = (v != prev);
      m_score = v;
      if (a_bot) begin
        if (m_lives == 1) begin
          m_lives = 0; m_state = ST_OVER;
        end else begin
          m_lives = m_lives - 1; m_state = ST_LOST; m_cnt = 0;
        end
      end
`ifdef BONUS_LIFE_EN
      if (m_state != ST_OVER && (v / 1000) > (prev / 1000) && m_lives < MAXL) m_lives++;
`endif
    end else if ((s == ST_IDLE || s == ST_OVER) && sg) begin
      m_score = 0; m_lives = INIT; m_br = 1; m_state = ST_PLAY; m_cnt = 0;
    end else if (s == ST_LOST && sof) begin
      m_cnt++;
      if (m_cnt == FRAMES) begin
        m_cnt = 0; m_state = ST_PLAY; m_br = 1;
      end
    end
    if (sof) begin
      a_good = p_good; a_bad = p_bad; a_bump = p_bump; a_bot = p_bot; a_dig = p_dig;
    end
    a_valid = sof;
    p_good = ng; p_bad = nb; p_bump = np; p_bot = nt; p_dig = nd;
  endtask

  task automatic check_all();
    check_eq("score", int'(bus.score), to_bcd(m_score));
    check_eq("lives", int'(bus.lives), m_lives);
    check_eq("gameState", int'(bus.gameState), m_state);
    check_eq("ballReset", int'(bus.ballReset), int'(m_br));
    check_eq("scoreChanged", int'(bus.scoreChanged), int'(m_sc));
  endtask

  task automatic drive(input bit sof, input bit sg, input bit g, input bit bd,
                       input bit bp, input bit sp, input bit bt, input int dig);
    bus.startOfFrame                = sof;
    bus.startGame                   = sg;
    bus.collisionSmileyObstacleGood = g;
    bus.collisionSmileyObstacleBad  = bd;
    bus.collisionSmileyBumperPulse  = bp;
    bus.collisionSmileySpringPulse  = sp;
    bus.collisionSmileyBottom       = bt;
    bus.scoreDigit                  = 4'(dig);
  endtask

  task automatic do_cycle(input bit sof, input bit sg, input bit g, input bit bd,
                          input bit bp, input bit sp, input bit bt, input int dig);
    resetN = 1'b1;
    drive(sof, sg, g, bd, bp, sp, bt, dig);
    model_step(0, sof, sg, g, bd, bp, bt, dig);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 9));
    model_step(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // One frame: boundary in cycle 0, hit pulses in cycle 2, bottom from cycle 1
  task automatic frame(input int len, input bit g, input int dig, input bit bd,
                       input bit bp, input bit bt);
    for (int i = 0; i < len; i++) begin
      do_cycle(i == 0, 1'b0, g && i == 2, bd && i == 2, bp && i == 2, i == 1,
               bt && i >= 1, dig);
    end
  endtask

  initial begin
    bit lvl;
    n_errors = 0;
    n_checks = 0;
    lvl      = 1'b0;
    resetN   = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) do_reset();
    check_eq("rst_state", int'(bus.gameState), 0);
    check_eq("rst_lives", int'(bus.lives), 0);

    // Game start
    repeat (2) do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle(0, 1, 0, 0, 0, 0, 0, 0);
    check_eq("start_lives", int'(bus.lives), 3);
    check_eq("start_ballreset", int'(bus.ballReset), 1);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // Good digit 7 plus bumper in one frame
    frame(5, 0, 0, 0, 0, 0);
    frame(5, 1, 7, 0, 1, 0);
    frame(5, 0, 0, 0, 0, 0);
    check_eq("plan_score12", int'(bus.score), 16'h0012);

    // Walk down to 2, then a bad hit saturates at 0
    repeat (3) frame(4, 0, 0, 1, 0, 0);
    frame(4, 1, 2, 1, 0, 0);
    frame(4, 0, 0, 1, 0, 0);
    repeat (3) frame(4, 0, 0, 0, 0, 0);
    check_eq("plan_sat_zero", int'(bus.score), 0);

    // Good pulse on the boundary cycle belongs to the next frame
    do_cycle(1, 0, 1, 0, 0, 0, 0, 4);
    repeat (4) do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("sof_good_deferred", int'(bus.score), 0);
    frame(5, 0, 0, 0, 0, 0);
    frame(5, 0, 0, 0, 0, 0);
    check_eq("sof_good_once", int'(bus.score), 16'h0004);

    // Two ball losses with full BALL_LOST wait each
    repeat (2) begin
      frame(3, 0, 0, 0, 0, 1);
      repeat (65) frame(3, 0, 0, 0, 0, 0);
    end
    check_eq("after_losses_lives", int'(bus.lives), 1);

    // Last life: bottom held for 500 cycles
    for (int i = 0; i < 500; i++) do_cycle(i % 8 == 0, 0, 0, 0, 0, 0, 1, 0);
    check_eq("gameover_state", int'(bus.gameState), 3);
    check_eq("gameover_lives", int'(bus.lives), 0);

    // Restart from GAME_OVER on a frame-boundary cycle
    do_cycle(1, 1, 0, 0, 0, 0, 0, 0);
    check_eq("restart_lives", int'(bus.lives), 3);
    check_eq("restart_score", int'(bus.score), 0);
    frame(4, 0, 0, 0, 0, 0);

    // Climb to 998, cross into the thousands, then saturate at 9999
    repeat (71) frame(3, 1, 9, 0, 1, 0);
    frame(3, 1, 4, 0, 0, 0);
    frame(3, 1, 5, 0, 0, 0);
    frame(3, 0, 0, 0, 0, 0);
    check_eq("plan_score1003", int'(bus.score), 16'h1003);
    repeat (700) frame(3, 1, 9, 0, 1, 0);
    frame(3, 0, 0, 0, 0, 0);
    check_eq("sat_9999", int'(bus.score), 16'h9999);
    frame(3, 1, 4, 1, 0, 0);
    frame(3, 0, 0, 0, 0, 0);
    check_eq("sat_add_then_sub", int'(bus.score), 16'h9996);

    // Random play
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) lvl = ~lvl;
      if ($urandom_range(0, 1999) == 0) do_reset();
      else do_cycle($urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                    lvl, $urandom_range(0, 9));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/score_lives_keeper.md
Name: score_lives_keeper

Overview:
- Consumer of the per-frame collision pulses produced by the collision detection logic; turns them into game consequences.
- Latches collision events during each video frame and applies them once at the next frame boundary.
- Maintains a 4-digit BCD score, a lives counter and the game-state FSM.
- Issues ball-reset requests to the ball movement logic; drives the score and lives display logic.

Parameters:
INIT_LIVES, 3, lives loaded on game start (1..MAX_LIVES)
MAX_LIVES, 7, lives ceiling (fits 3 bits)
BUMPER_POINTS, 5, BCD points added per bumper hit (0..9)
BAD_PENALTY, 3, BCD points subtracted per bad-obstacle hit (0..9)
BALL_LOST_FRAMES, 60, frames spent in BALL_LOST before the ball is relaunched (>=1)

Ports:
clk  in  1  system clock
resetN  in  1  synchronous active-low reset
startOfFrame  in  1  one-cycle pulse at each frame start
startGame  in  1  one-cycle pulse requesting a new game
collisionSmileyObstacleGood  in  1  good-obstacle hit pulse
collisionSmileyObstacleBad  in  1  bad-obstacle hit pulse
collisionSmileyBumperPulse  in  1  bumper hit pulse
collisionSmileySpringPulse  in  1  spring hit pulse
collisionSmileyBottom  in  1  ball touching bottom (level, may be high for many cycles)
scoreDigit  in  4  value of the number drawn under the ball (0..9), valid with the good-obstacle pulse
score  out  16  BCD score, digit 3 = [15:12]
lives  out  3  remaining lives
gameState  out  2  0 IDLE, 1 PLAYING, 2 BALL_LOST, 3 GAME_OVER
ballReset  out  1  one-cycle pulse: reposition and relaunch the ball
scoreChanged  out  1  one-cycle pulse when score changes value

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-low on `resetN`.
- Reset (resetN low at a clk edge):
  - score=0, lives=0, gameState=IDLE.
  - ballReset=0, scoreChanged=0.
  - All pending flags, apply registers and the frame counter cleared.
  - Reset mid-frame or mid-BALL_LOST discards everything.
- Event capture, PLAYING only:
  - Sticky pending flags: good, bad, bumper, bottom.
  - Each flag is set on its input pulse/level.
  - On the first good pulse of a frame, scoreDigit is latched into the pending digit; later good pulses in the same frame are ignored.
  - The spring pulse is accepted and has no effect on score.
  - In any other state, inputs are ignored and pending flags are held at 0.
- Frame boundary:
  - In the startOfFrame cycle, pending flags are copied to the apply registers and cleared.
  - An event arriving in that same cycle is captured into the freshly cleared pending flags, i.e. it belongs to the next frame. It is never lost or double-counted.
- Score apply, the cycle after startOfFrame:
  - score_next = sat(score + good·digit + bumper·BUMPER_POINTS − bad·BAD_PENALTY).
  - BCD arithmetic throughout, digit-wise carry/borrow.
  - Saturates at 9999 on overflow and at 0 on underflow.
  - Add terms are applied before the subtraction (9999 + good 4 − bad 3 = 9996).
  - Latency: score updates 2 clk after the startOfFrame pulse.
  - scoreChanged pulses in the update cycle only if the value differs.
- Lives and FSM:
  - IDLE: on startGame → score=0, lives=INIT_LIVES, ballReset pulse, go to PLAYING.
  - PLAYING: in the apply cycle with bottom set, lives decrements (score apply still happens in the same cycle).
    - If lives was 1 → lives=0, go to GAME_OVER.
    - Otherwise go to BALL_LOST; frame counter = 0.
  - BALL_LOST: the counter increments on each startOfFrame. On reaching BALL_LOST_FRAMES → ballReset pulse, go to PLAYING.
  - GAME_OVER: score and lives are frozen. startGame behaves as in IDLE.
  - startGame in PLAYING or BALL_LOST is ignored.
  - startGame coinciding with startOfFrame in IDLE: game starts, and that frame's boundary is treated as empty.
- ballReset and scoreChanged are exactly one cycle wide and never asserted in reset.

Optional Feature:
BONUS_LIFE_EN
- Defined: when an apply cycle raises the thousands digit (score[15:12]) above its previous value, lives increments by 1, capped at MAX_LIVES.
  - The bonus is applied after any bottom decrement in the same cycle.
  - A decrement to 0 still goes to GAME_OVER; the bonus does not rescue it.
- Undefined: lives only change on game start and ball loss. No extra logic is synthesized.

Test Plan:
- Reset, then startGame → score=0x0000, lives=3, gameState=1, one ballReset pulse.
- In PLAYING: good pulse with scoreDigit=7, plus a bumper pulse in the same frame → 2 clk after startOfFrame, score=0x0012 and one scoreChanged pulse.
- score=0x0002, bad pulse → score=0x0000 (saturated). No scoreChanged on a later empty frame.
- Good pulse coinciding with startOfFrame → applied at the following frame boundary, not the current one. Added exactly once.
- lives=1, bottom held high for 500 cycles → lives=0, gameState=3. A startGame then restarts with lives=3, score=0.
- lives=3, bottom → lives=2, gameState=2. After 60 startOfFrame pulses → one ballReset, gameState=1.
  - With BONUS_LIFE_EN: score 0x0998 plus a good hit with digit 5 → score=0x1003, lives+1.
